// File: rtl/core_fetch_unit.sv
// rtl/core_fetch_unit.sv - instruction fetch front end with prefetch queue and redirect flush
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module core_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rsp_ptr;
    logic [PW-1:0]   drop_cnt;
    logic [XLEN-1:0] slot_pc   [DEPTH];
    logic [31:0]     slot_data [DEPTH];
    logic [DEPTH-1:0] slot_ok;
    logic [XLEN-1:0] last_pc;
    logic [31:0]     last_instr;

    logic [PW-1:0]   occupancy;
    logic [PW-1:0]   pending;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   rsp_idx;
    logic            issue;
    logic            pop;
    logic            rsp_drop;
    logic            rsp_take;
    logic [PW:0]     drop_sum;
    logic            unused_bits;

    // occupancy counts every allocated slot; pending only those still waiting for data
    assign occupancy = wr_ptr - rd_ptr;
    assign pending   = wr_ptr - rsp_ptr;
    assign wr_idx    = wr_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];
    assign rsp_idx   = rsp_ptr[AW-1:0];

    assign imem_req_valid = (occupancy < DEPTH_P) && !redirect_valid && rst_n;
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid && imem_req_ready;

    assign if_valid = (occupancy != '0) && slot_ok[rd_idx];
    assign if_pc    = if_valid ? slot_pc[rd_idx]   : last_pc;
    assign if_instr = if_valid ? slot_data[rd_idx] : last_instr;
    assign pop      = if_valid && if_ready && !redirect_valid;

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_take = imem_rsp_valid && (drop_cnt == '0) && (pending != '0);

    // Everything still in flight becomes stale; a response landing this cycle is already accounted for.
    assign drop_sum = {1'b0, drop_cnt} + {1'b0, pending} - {{PW{1'b0}}, imem_rsp_valid};

    assign unused_bits = &{1'b0, redirect_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rsp_ptr  <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rsp_ptr  <= '0;
            drop_cnt <= drop_sum[PW-1:0];
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                wr_ptr   <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - PW'(1);
            end
            if (rsp_take) begin
                rsp_ptr <= rsp_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_ok <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            slot_ok <= '0;
        end else begin
            // An allocated wr slot never aliases the rsp slot, so both writes may coexist.
            if (issue) begin
                slot_ok[wr_idx] <= 1'b0;
                slot_pc[wr_idx] <= fetch_pc;
            end
            if (rsp_take) begin
                slot_ok[rsp_idx]   <= 1'b1;
                slot_data[rsp_idx] <= imem_rsp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc    <= '0;
            last_instr <= '0;
        end else if (if_valid) begin
            last_pc    <= slot_pc[rd_idx];
            last_instr <= slot_data[rd_idx];
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (imem_rsp_valid && (redirect_valid || rsp_drop)) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
        end
    end
`endif

    rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> ((drop_cnt != '0) || (pending != '0)));

endmodule

// File: tb/tb_core_fetch_unit.sv
// tb/tb_core_fetch_unit.sv - directed self-checking bench for core_fetch_unit
module tb_core_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] memq[$];
    int          budget = 0;
    logic [31:0] got_pc;
    logic [31:0] got_ins;
    logic        seen;

    core_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic to_neg;
        @(negedge clk);
    endtask

    // Memory model: records accepted requests, returns them in order one per cycle while budget lasts.
    task automatic to_next;
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        if (acc) memq.push_back(a);
        #1;
        if (budget > 0 && memq.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(memq.pop_front());
            budget--;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        budget         = 0;
        memq.delete();
        #1;
        to_neg;
        to_next;
        rst_n = 1'b1;
    endtask

    task automatic wait_first(input int maxc, output logic ok, output logic [31:0] pc, output logic [31:0] ins);
        ok  = 1'b0;
        pc  = '0;
        ins = '0;
        for (int i = 0; i < maxc && !ok; i++) begin
            to_neg;
            if (if_valid) begin
                ok  = 1'b1;
                pc  = if_pc;
                ins = if_instr;
            end
            to_next;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b1;
        #1;

        // reset values
        to_neg;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        to_next;
        rst_n  = 1'b1;
        budget = 1000;

        // streaming at one instruction per cycle
        for (int k = 0; k < 8; k++) begin
            to_neg;
            chk("stream_req_valid", imem_req_valid, 1'b1);
            chk("stream_req_addr", imem_req_addr, 32'(4 * k));
            if (k >= 2) begin
                chk("stream_if_valid", if_valid, 1'b1);
                chk("stream_if_pc", if_pc, 32'(4 * (k - 2)));
                chk("stream_if_instr", if_instr, word_at(32'(4 * (k - 2))));
            end else begin
                chk("stream_if_idle", if_valid, 1'b0);
            end
            to_next;
        end

        // full queue back-pressure then drain
        do_reset;
        if_ready = 1'b0;
        budget   = 1000;
        for (int k = 0; k < 4; k++) begin
            to_neg;
            chk("fill_req_valid", imem_req_valid, 1'b1);
            chk("fill_req_addr", imem_req_addr, 32'(4 * k));
            to_next;
        end
        for (int k = 0; k < 2; k++) begin
            to_neg;
            chk("full_req_valid", imem_req_valid, 1'b0);
            chk("full_if_valid", if_valid, 1'b1);
            chk("full_if_pc", if_pc, 32'h0);
            to_next;
        end
        if_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            to_neg;
            chk("drain_if_valid", if_valid, 1'b1);
            chk("drain_if_pc", if_pc, 32'(4 * k));
            if (k == 0) chk("drain_req_blocked", imem_req_valid, 1'b0);
            if (k == 1) begin
                chk("drain_req_valid", imem_req_valid, 1'b1);
                chk("drain_req_addr", imem_req_addr, 32'h10);
            end
            to_next;
        end

        // redirect with two requests in flight
        do_reset;
        if_ready = 1'b1;
        budget   = 0;
        to_neg;
        chk("inflight_addr0", imem_req_addr, 32'h0);
        to_next;
        to_neg;
        chk("inflight_addr1", imem_req_addr, 32'h4);
        to_next;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        to_neg;
        chk("redir_no_issue", imem_req_valid, 1'b0);
        to_next;
        redirect_valid = 1'b0;
        budget         = 1000;
        to_neg;
        chk("redir_req_valid", imem_req_valid, 1'b1);
        chk("redir_req_addr", imem_req_addr, 32'h100);
        to_next;
        wait_first(12, seen, got_pc, got_ins);
        chk("redir_seen", seen, 1'b1);
        chk("redir_first_pc", got_pc, 32'h100);
        chk("redir_first_instr", got_ins, word_at(32'h100));
`ifdef FETCH_PERF_EN
        chk("redir_perf_dropped", perf_dropped, 32'd2);
`endif

        // unaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        to_neg;
        chk("align_no_issue", imem_req_valid, 1'b0);
        to_next;
        redirect_valid = 1'b0;
        to_neg;
        chk("align_req_valid", imem_req_valid, 1'b1);
        chk("align_req_addr", imem_req_addr, 32'h200);
        to_next;
        wait_first(12, seen, got_pc, got_ins);
        chk("align_seen", seen, 1'b1);
        chk("align_first_pc", got_pc, 32'h200);

        // redirect coinciding with a response and a pop
        do_reset;
        if_ready = 1'b1;
        budget   = 1000;
        for (int k = 0; k < 3; k++) begin
            to_neg;
            to_next;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        to_neg;
        chk("coinc_if_valid", if_valid, 1'b1);
        chk("coinc_if_pc", if_pc, 32'h4);
        chk("coinc_rsp_present", imem_rsp_valid, 1'b1);
        to_next;
        redirect_valid = 1'b0;
        to_neg;
        chk("coinc_empty", if_valid, 1'b0);
        chk("coinc_hold_pc", if_pc, 32'h4);
        chk("coinc_hold_instr", if_instr, word_at(32'h4));
        chk("coinc_req_addr", imem_req_addr, 32'h40);
`ifdef FETCH_PERF_EN
        chk("coinc_perf_fetched", perf_fetched, 32'd1);
        chk("coinc_perf_dropped", perf_dropped, 32'd1);
`endif
        to_next;
        wait_first(12, seen, got_pc, got_ins);
        chk("coinc_seen", seen, 1'b1);
        chk("coinc_first_pc", got_pc, 32'h40);

        // asynchronous reset with three responses outstanding
        do_reset;
        if_ready = 1'b1;
        budget   = 2;
        for (int k = 0; k < 5; k++) begin
            to_neg;
            if (k == 3) chk("arst_pre_pc", if_pc, 32'h4);
            to_next;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", imem_req_valid, 1'b0);
        chk("arst_if_valid", if_valid, 1'b0);
        chk("arst_if_pc", if_pc, 32'h0);
        chk("arst_if_instr", if_instr, 32'h0);
        chk("arst_req_addr", imem_req_addr, 32'h0);
        memq.delete();
        imem_rsp_valid = 1'b0;
        budget         = 1000;
        to_neg;
        to_next;
        rst_n = 1'b1;
        to_neg;
        chk("arst_restart_valid", imem_req_valid, 1'b1);
        chk("arst_restart_addr", imem_req_addr, 32'h0);
        to_next;
        wait_first(12, seen, got_pc, got_ins);
        chk("arst_seen", seen, 1'b1);
        chk("arst_first_pc", got_pc, 32'h0);
        chk("arst_first_instr", got_ins, word_at(32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
